// File: rtl/beat_scheduler.sv
// Metronome beat sequencer: derives the beat period from BPM with a restoring divider,
// then counts beats, walks the step pattern and drives the click gate and accent.
module beat_scheduler #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned STEPS    = 4,
  parameter int unsigned STEP_W   = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [9:0]        bpm_i,
  input  logic [STEPS-1:0]  pattern_i,
  output logic              beat_tick_o,
  output logic [STEP_W-1:0] step_o,
  output logic              click_o,
  output logic              accent_o,
  output logic              period_valid_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W     = 32;
  localparam int unsigned BPM_W     = 10;
  localparam int unsigned DCNT_W    = 6;
  localparam int unsigned DIV_STEPS = 32;
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(64'(CLK_FREQ) * 64'd60);

  typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CNT_W-1:0]    dq_q, dq_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [BPM_W-1:0]    bpm_q, bpm_d;
  logic [DCNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                tick_q, tick_d;
  logic                click_q, click_d;
  logic                accent_q, accent_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [CNT_W:0]      trial;
  logic [STEP_W-1:0]   step_inc;
  logic                stop;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    bpm_d     = bpm_q;
    div_cnt_d = div_cnt_q;
    step_d    = step_q;
    tick_d    = 1'b0;
    click_d   = click_q;
    accent_d  = accent_q;
    valid_d   = valid_q;
    busy_d    = busy_q;

    trial    = {rem_q, dq_q[CNT_W-1]};
    step_inc = (step_q == STEP_W'(STEPS - 1)) ? '0 : step_q + STEP_W'(1);
    stop     = !enable_i || (bpm_i == '0);

    // Beat counting keeps running on the committed period, including during a re-divide
    if (valid_q) begin
      if (cnt_q >= period_q - CNT_W'(1)) begin
        cnt_d    = '0;
        tick_d   = 1'b1;
        step_d   = step_inc;
        click_d  = pattern_i[step_inc];
        accent_d = pattern_i[step_inc] && (step_inc == '0);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == (period_q >> 1)) begin
          click_d  = 1'b0;
          accent_d = 1'b0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (!stop) begin
          bpm_d     = bpm_i;
          dq_d      = DIVIDEND;
          rem_d     = '0;
          div_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_cnt_q != DCNT_W'(DIV_STEPS)) begin
          if (trial >= (CNT_W+1)'(bpm_q)) begin
            rem_d = CNT_W'(trial - (CNT_W+1)'(bpm_q));
            dq_d  = {dq_q[CNT_W-2:0], 1'b1};
          end else begin
            rem_d = trial[CNT_W-1:0];
            dq_d  = {dq_q[CNT_W-2:0], 1'b0};
          end
          div_cnt_d = div_cnt_q + DCNT_W'(1);
          if (div_cnt_q == DCNT_W'(DIV_STEPS - 1)) busy_d = 1'b0;
        end else begin
          period_d = dq_q;
          state_d  = RUN;
          if (!valid_q) begin
            valid_d = 1'b1;
            cnt_d   = dq_q - CNT_W'(1);
            step_d  = STEP_W'(STEPS - 1);
          end
        end
      end
      RUN: begin
        if (bpm_i != bpm_q) begin
          bpm_d     = bpm_i;
          dq_d      = DIVIDEND;
          rem_d     = '0;
          div_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = DIV;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable or zero BPM drops everything back to a quiet idle
    if (stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      step_d   = '0;
      tick_d   = 1'b0;
      click_d  = 1'b0;
      accent_d = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      dq_q      <= '0;
      rem_q     <= '0;
      bpm_q     <= '0;
      div_cnt_q <= '0;
      step_q    <= '0;
      tick_q    <= 1'b0;
      click_q   <= 1'b0;
      accent_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      bpm_q     <= bpm_d;
      div_cnt_q <= div_cnt_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
      click_q   <= click_d;
      accent_q  <= accent_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign beat_tick_o    = tick_q;
  assign step_o         = step_q;
  assign click_o        = click_q;
  assign accent_o       = accent_q;
  assign period_valid_o = valid_q;
  assign busy_o         = busy_q;

endmodule
